// File: rtl/enemy_agent.sv
// Enemy controller: patrol or greedy chase movement, bomberman contact and explosion kill detection,
// and sprite-relative pixel coordinates for an external colour ROM.
module enemy_agent #(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned SPRITE_W   = 16,
  parameter int unsigned SPRITE_H   = 16,
  parameter int unsigned MIN_X      = 143,
  parameter int unsigned MAX_X      = 784,
  parameter int unsigned MIN_Y      = 34,
  parameter int unsigned MAX_Y      = 516,
  parameter int unsigned TICK_LIMIT = 1400000,
  parameter int unsigned MODE       = 0,
  parameter logic [3:0]  START_DIR  = 4'b1000,
  parameter int unsigned EXP_ARM    = 48,
  parameter int unsigned EXP_TILE   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] set_x,
  input  logic [COORD_W-1:0] set_y,
  input  logic [3:0]         blocked,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [COORD_W-1:0] e_x,
  input  logic [COORD_W-1:0] e_y,
  input  logic               explosion_en,
  input  logic [COORD_W-1:0] v_x,
  input  logic [COORD_W-1:0] v_y,
  output logic [COORD_W-1:0] enemy_x,
  output logic [COORD_W-1:0] enemy_y,
  output logic [3:0]         dir,
  output logic               enemy_on,
  output logic [COORD_W-1:0] sprite_row,
  output logic [COORD_W-1:0] sprite_col,
  output logic               death_signal,
  output logic               enemy_killed
);

  // Two guard bits keep every sum of a coordinate and a geometry constant free of overflow.
  localparam int unsigned XW = COORD_W + 2;
  localparam int unsigned DW = COORD_W + 1;
  localparam int unsigned CW = (TICK_LIMIT < 1) ? 1 : $clog2(TICK_LIMIT + 1);

  localparam logic [XW-1:0] LIM_X_LO = XW'(MIN_X);
  localparam logic [XW-1:0] LIM_X_HI = XW'(MAX_X - SPRITE_W);
  localparam logic [XW-1:0] LIM_Y_LO = XW'(MIN_Y);
  localparam logic [XW-1:0] LIM_Y_HI = XW'(MAX_Y - SPRITE_H);
  localparam logic [XW-1:0] SW       = XW'(SPRITE_W);
  localparam logic [XW-1:0] SH       = XW'(SPRITE_H);
  localparam logic [XW-1:0] ARM      = XW'(EXP_ARM);
  localparam logic [XW-1:0] TILE     = XW'(EXP_TILE);

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DEAD} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] enemy_x_q, enemy_x_d;
  logic [COORD_W-1:0] enemy_y_q, enemy_y_d;
  logic [3:0]         dir_q, dir_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               death_q, death_d;
  logic               killed_q, killed_d;

  logic [XW-1:0] ex_w, ey_w, bx_w, by_w, cx_w, cy_w, vx_w, vy_w;
  logic [XW-1:0] arm_x_lo, arm_x_hi, arm_y_lo, arm_y_hi, tile_x_hi, tile_y_hi;
  logic          blk_l, blk_r, blk_u, blk_d;
  logic          overlap, h_hit, v_hit, hit, tick;

  assign ex_w = XW'(enemy_x_q);
  assign ey_w = XW'(enemy_y_q);
  assign bx_w = XW'(b_x);
  assign by_w = XW'(b_y);
  assign cx_w = XW'(e_x);
  assign cy_w = XW'(e_y);
  assign vx_w = XW'(v_x);
  assign vy_w = XW'(v_y);

  assign blk_l = blocked[0] | (ex_w <= LIM_X_LO);
  assign blk_r = blocked[1] | (ex_w >= LIM_X_HI);
  assign blk_u = blocked[2] | (ey_w <= LIM_Y_LO);
  assign blk_d = blocked[3] | (ey_w >= LIM_Y_HI);

  assign overlap = (bx_w < ex_w + SW) && (ex_w < bx_w + SW) &&
                   (by_w < ey_w + SH) && (ey_w < by_w + SH);

  // Arm lower bounds clamp at zero instead of wrapping around.
  assign arm_x_lo  = (cx_w >= ARM) ? (cx_w - ARM) : '0;
  assign arm_y_lo  = (cy_w >= ARM) ? (cy_w - ARM) : '0;
  assign arm_x_hi  = cx_w + TILE + ARM;
  assign arm_y_hi  = cy_w + TILE + ARM;
  assign tile_x_hi = cx_w + TILE;
  assign tile_y_hi = cy_w + TILE;

  assign h_hit = (ex_w < arm_x_hi) && (arm_x_lo < ex_w + SW) &&
                 (ey_w < tile_y_hi) && (cy_w < ey_w + SH);
  assign v_hit = (ex_w < tile_x_hi) && (cx_w < ex_w + SW) &&
                 (ey_w < arm_y_hi) && (arm_y_lo < ey_w + SH);
  assign hit   = explosion_en & (h_hit | v_hit);

  assign tick = (state_q == S_MOVE) && (cnt_q == CW'(TICK_LIMIT));

  // Patrol: blocked test for the current heading and the L->U->R->D rotation.
  logic       patrol_blk;
  logic [3:0] patrol_rot;

  always_comb begin
    patrol_blk = 1'b1;
    patrol_rot = DIR_L;
    case (dir_q)
      DIR_L: begin patrol_blk = blk_l; patrol_rot = DIR_U; end
      DIR_U: begin patrol_blk = blk_u; patrol_rot = DIR_R; end
      DIR_R: begin patrol_blk = blk_r; patrol_rot = DIR_D; end
      DIR_D: begin patrol_blk = blk_d; patrol_rot = DIR_L; end
      default: begin patrol_blk = 1'b1; patrol_rot = DIR_L; end
    endcase
  end

  // Chase: signed deltas kept as two's complement in DW bits, magnitudes taken by negation.
  logic [DW-1:0] dx, dy, adx, ady;
  logic [3:0]    h_dir, v_dir, chase_dir;
  logic          h_ok, v_ok, chase_step;

  always_comb begin
    dx    = {1'b0, b_x} - {1'b0, enemy_x_q};
    dy    = {1'b0, b_y} - {1'b0, enemy_y_q};
    adx   = dx[DW-1] ? (DW'(0) - dx) : dx;
    ady   = dy[DW-1] ? (DW'(0) - dy) : dy;
    h_dir = dx[DW-1] ? DIR_L : DIR_R;
    v_dir = dy[DW-1] ? DIR_U : DIR_D;
    h_ok  = (dx != '0) && !(dx[DW-1] ? blk_l : blk_r);
    v_ok  = (dy != '0) && !(dy[DW-1] ? blk_u : blk_d);
    chase_dir  = dir_q;
    chase_step = 1'b0;
    if (adx >= ady) begin
      if (h_ok) begin
        chase_dir  = h_dir;
        chase_step = 1'b1;
      end else if (v_ok) begin
        chase_dir  = v_dir;
        chase_step = 1'b1;
      end
    end else begin
      if (v_ok) begin
        chase_dir  = v_dir;
        chase_step = 1'b1;
      end else if (h_ok) begin
        chase_dir  = h_dir;
        chase_step = 1'b1;
      end
    end
  end

  logic [3:0] step_dir;

  always_comb begin
    state_d   = state_q;
    enemy_x_d = enemy_x_q;
    enemy_y_d = enemy_y_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    step_dir  = '0;
    killed_d  = killed_q | hit;
    death_d   = death_q | (overlap & ~killed_q & ~hit);

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_DEAD;
          dir_d   = '0;
        end else if (start) begin
          state_d = S_MOVE;
          cnt_d   = '0;
          dir_d   = (MODE == 0) ? START_DIR : 4'b0000;
        end
      end
      S_MOVE: begin
        if (hit) begin
          state_d = S_DEAD;
          dir_d   = '0;
        end else begin
          cnt_d = tick ? '0 : cnt_q + CW'(1);
          if (tick) begin
            if (MODE == 0) begin
              if (!patrol_blk) step_dir = dir_q;
              else             dir_d    = patrol_rot;
            end else begin
              dir_d = chase_dir;
              if (chase_step) step_dir = chase_dir;
            end
          end
        end
      end
      default: begin
        state_d = S_DEAD;
        dir_d   = '0;
      end
    endcase

    case (step_dir)
      DIR_L:   enemy_x_d = enemy_x_q - COORD_W'(1);
      DIR_R:   enemy_x_d = enemy_x_q + COORD_W'(1);
      DIR_U:   enemy_y_d = enemy_y_q - COORD_W'(1);
      DIR_D:   enemy_y_d = enemy_y_q + COORD_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      enemy_x_q <= set_x;
      enemy_y_q <= set_y;
      dir_q     <= '0;
      cnt_q     <= '0;
      death_q   <= 1'b0;
      killed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      enemy_x_q <= enemy_x_d;
      enemy_y_q <= enemy_y_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      death_q   <= death_d;
      killed_q  <= killed_d;
    end
  end

  assign enemy_x      = enemy_x_q;
  assign enemy_y      = enemy_y_q;
  assign dir          = dir_q;
  assign death_signal = death_q;
  assign enemy_killed = killed_q;
  assign sprite_row   = v_y - enemy_y_q;
  assign sprite_col   = v_x - enemy_x_q;
  assign enemy_on     = (vx_w >= ex_w) && (vx_w < ex_w + SW) &&
                        (vy_w >= ey_w) && (vy_w < ey_w + SH) && !killed_q;

endmodule

// File: tb/tb_enemy_agent.sv
// Directed bench for enemy_agent: one PATROL and one CHASE instance sharing the playfield inputs.
module tb_enemy_agent;

  logic       clk;
  logic       reset;
  logic       start_p, start_c;
  logic [9:0] set_px, set_py, set_cx, set_cy;
  logic [3:0] blocked;
  logic [9:0] b_x, b_y, e_x, e_y, v_x, v_y;
  logic       explosion_en;

  logic [9:0] p_x, p_y, p_row, p_col, c_x, c_y, c_row, c_col;
  logic [3:0] p_dir, c_dir;
  logic       p_on, p_death, p_kill, c_on, c_death, c_kill;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  enemy_agent #(.MODE(0), .TICK_LIMIT(3)) u_p (
    .clk(clk), .reset(reset), .start(start_p), .set_x(set_px), .set_y(set_py),
    .blocked(blocked), .b_x(b_x), .b_y(b_y), .e_x(e_x), .e_y(e_y),
    .explosion_en(explosion_en), .v_x(v_x), .v_y(v_y),
    .enemy_x(p_x), .enemy_y(p_y), .dir(p_dir), .enemy_on(p_on),
    .sprite_row(p_row), .sprite_col(p_col), .death_signal(p_death), .enemy_killed(p_kill)
  );

  enemy_agent #(.MODE(1), .TICK_LIMIT(3)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .set_x(set_cx), .set_y(set_cy),
    .blocked(blocked), .b_x(b_x), .b_y(b_y), .e_x(e_x), .e_y(e_y),
    .explosion_en(explosion_en), .v_x(v_x), .v_y(v_y),
    .enemy_x(c_x), .enemy_y(c_y), .dir(c_dir), .enemy_on(c_on),
    .sprite_row(c_row), .sprite_col(c_col), .death_signal(c_death), .enemy_killed(c_kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_p = 1'b0; start_c = 1'b0;
    set_px = 10'd200; set_py = 10'd100; set_cx = 10'd300; set_cy = 10'd200;
    blocked = 4'b0000; b_x = '0; b_y = '0; e_x = '0; e_y = '0;
    explosion_en = 1'b0; v_x = '0; v_y = '0;
    tick(2);
    expect_val("rst_x", 200);     check_next(p_x);
    expect_val("rst_y", 100);     check_next(p_y);
    expect_val("rst_dir", 0);     check_next(p_dir);
    expect_val("rst_death", 0);   check_next(p_death);
    expect_val("rst_kill", 0);    check_next(p_kill);

    // Patrol stepping cadence with TICK_LIMIT=3.
    reset = 1'b0; start_p = 1'b1;
    expect_val("p_start_dir", 8); expect_val("p_start_x", 200);
    tick(1); check_next(p_dir); check_next(p_x);
    expect_val("p_pre_tick_x", 200);
    tick(3); check_next(p_x);
    expect_val("p_step1_x", 199);
    tick(1); check_next(p_x);
    expect_val("p_step2_x", 198);
    tick(4); check_next(p_x);

    // Patrol at the playfield corner.
    reset = 1'b1; set_px = 10'd144; set_py = 10'd35;
    tick(1);
    reset = 1'b0;
    tick(1);
    expect_val("p_corner_x", 143);
    tick(4); check_next(p_x);
    expect_val("p_minx_x", 143); expect_val("p_minx_dir", 2);
    tick(4); check_next(p_x); check_next(p_dir);
    expect_val("p_up_y", 34);
    tick(4); check_next(p_y);
    expect_val("p_miny_y", 34); expect_val("p_miny_dir", 4);
    tick(4); check_next(p_y); check_next(p_dir);
    blocked = 4'b0010;
    expect_val("p_blkr_x", 143); expect_val("p_blkr_dir", 1);
    tick(4); check_next(p_x); check_next(p_dir);
    blocked = 4'b0000;
    expect_val("p_down_y", 35);
    tick(4); check_next(p_y);

    // Chase toward bomberman at (340,210).
    reset = 1'b1; start_p = 1'b0; b_x = 10'd340; b_y = 10'd210;
    tick(1);
    reset = 1'b0; start_c = 1'b1;
    expect_val("c_start_dir", 0);
    tick(1); check_next(c_dir);
    expect_val("c_r_dir", 4); expect_val("c_r_x", 301);
    tick(4); check_next(c_dir); check_next(c_x);
    blocked = 4'b0010;
    expect_val("c_d_dir", 1); expect_val("c_d_y", 201); expect_val("c_d_x", 301);
    tick(4); check_next(c_dir); check_next(c_y); check_next(c_x);
    blocked = 4'b1111;
    expect_val("c_hold_x", 301); expect_val("c_hold_y", 201); expect_val("c_hold_dir", 1);
    tick(4); check_next(c_x); check_next(c_y); check_next(c_dir);

    // Contact edge cases with the chaser held at (301,201).
    b_x = 10'd317; b_y = 10'd201;
    expect_val("death_adjacent", 0);
    tick(1); check_next(c_death);
    b_x = 10'd316;
    expect_val("death_overlap", 1);
    tick(1); check_next(c_death);
    b_x = 10'd0; b_y = 10'd0;
    expect_val("death_sticky", 1);
    tick(2); check_next(c_death);

    // Explosion kill; chaser sits idle under the blast with bomberman arriving the same clock.
    reset = 1'b1; start_c = 1'b0; start_p = 1'b0; blocked = 4'b0000;
    set_px = 10'd345; set_py = 10'd300; set_cx = 10'd400; set_cy = 10'd300;
    v_x = 10'd350; v_y = 10'd305;
    tick(1);
    expect_val("p_on_live", 1); expect_val("p_col", 5); expect_val("p_row", 5);
    check_next(p_on); check_next(p_col); check_next(p_row);
    reset = 1'b0; start_p = 1'b1;
    tick(1);
    e_x = 10'd400; e_y = 10'd300; explosion_en = 1'b1; b_x = 10'd400; b_y = 10'd300;
    expect_val("p_killed", 1); expect_val("p_dead_dir", 0); expect_val("p_on_dead", 0);
    expect_val("c_killed", 1); expect_val("c_kill_wins", 0);
    tick(1);
    explosion_en = 1'b0;
    check_next(p_kill); check_next(p_dir); check_next(p_on);
    check_next(c_kill); check_next(c_death);
    expect_val("p_frozen_x", 345); expect_val("c_no_new_death", 0);
    tick(8); check_next(p_x); check_next(c_death);

    // Asynchronous reset without a clock edge.
    set_px = 10'd200; set_py = 10'd100; reset = 1'b1;
    expect_val("arst_p_kill", 0); expect_val("arst_c_kill", 0); expect_val("arst_p_x", 200);
    #2; check_next(p_kill); check_next(c_kill); check_next(p_x);
    b_x = 10'd0; b_y = 10'd0;
    tick(1);
    reset = 1'b0;
    tick(1);
    expect_val("mv_x", 199);
    tick(4); check_next(p_x);
    b_x = 10'd199; b_y = 10'd100;
    expect_val("mv_death", 1);
    tick(1); check_next(p_death);
    b_x = 10'd0; b_y = 10'd0;
    reset = 1'b1;
    expect_val("mid_x", 200); expect_val("mid_y", 100); expect_val("mid_dir", 0);
    expect_val("mid_death", 0);
    #2; check_next(p_x); check_next(p_y); check_next(p_dir); check_next(p_death);
    reset = 1'b0;
    expect_val("restart_hold_x", 200);
    tick(4); check_next(p_x);
    expect_val("restart_step_x", 199);
    tick(1); check_next(p_x);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
